cpu_stream_loader: RTL and testbench

//  Byte-stream program/data loader that sits in front of the CPU core. It accepts

---
 rtl/cpu_loader_pkg.sv | 20 ++
 rtl/cpu_stream_loader_if.sv | 23 ++
 rtl/cpu_stream_loader.sv | 148 ++++++++++++++
 tb/tb_cpu_stream_loader.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_loader_pkg.sv
// rtl/cpu_loader_pkg.sv - shared opcodes, command bit positions and FSM states for the stream loader
package cpu_loader_pkg;

    localparam logic [1:0] OP_CTRL     = 2'b00;
    localparam logic [1:0] OP_SET_ADDR = 2'b01;
    localparam logic [1:0] OP_BURST    = 2'b10;
    localparam logic [1:0] OP_RUN      = 2'b11;

    localparam int CMD_OP_HI   = 7;
    localparam int CMD_OP_LO   = 6;
    localparam int CMD_ARG_BIT = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_CHK  = 2'd3
    } state_t;

endpackage

// File: rtl/cpu_stream_loader_if.sv
// rtl/cpu_stream_loader_if.sv - command stream input and memory write port bundle for the loader
interface cpu_stream_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_sel, mem_addr, mem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_sel, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cpu_stream_loader.sv
// rtl/cpu_stream_loader.sv - framed byte-stream loader for CPU memories with halt/run control (optional checksum: LOADER_CHECKSUM_EN)
module cpu_stream_loader
    import cpu_loader_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 5,
    parameter int IMEM_DEPTH = 32,
    parameter int DMEM_DEPTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    cpu_stream_loader_if.slave  bus,
    output logic                cpu_halt,
    output logic                busy,
    output logic                err
);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] ptr;
    logic              sel;
    logic [5:0]        cnt;
    logic [DATA_W-1:0] csum;
    logic              ready_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              halt_q;
    logic              err_q;

    logic              accept;
    logic [1:0]        op;
    logic              arg;
    logic              in_range;
    logic [31:0]       ptr_ext;

    assign accept  = bus.in_valid & ready_q;
    assign op      = bus.in_data[CMD_OP_HI:CMD_OP_LO];
    assign arg     = bus.in_data[CMD_ARG_BIT];
    assign ptr_ext = {{(32-ADDR_W){1'b0}}, ptr};

    assign bus.in_ready  = ready_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_sel   = sel;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign cpu_halt      = halt_q;
    assign err           = err_q;
    assign busy          = (state != S_IDLE);

    // Frame sequencing: command word, then address word or payload words (and checksum)
    always_comb begin
        state_nx = state;
        in_range = sel ? (ptr_ext < 32'(IMEM_DEPTH)) : (ptr_ext < 32'(DMEM_DEPTH));
        case (state)
            S_IDLE: begin
                if (accept && op == OP_SET_ADDR) state_nx = S_ADDR;
                else if (accept && op == OP_BURST) state_nx = S_DATA;
            end
            S_ADDR: begin
                if (accept) state_nx = S_IDLE;
            end
            S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                if (accept && cnt == 6'd0) state_nx = S_CHK;
`else
                if (accept && cnt == 6'd0) state_nx = S_IDLE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) state_nx = S_IDLE;
            end
`endif
            default: state_nx = S_IDLE;
        endcase
    end

    // State register; reset abandons any frame in progress
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Command effects, pointer/count bookkeeping and the registered memory write
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            sel     <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            halt_q  <= 1'b1;
            err_q   <= 1'b0;
            cnt     <= 6'd0;
            ptr     <= '0;
            csum    <= '0;
        end else begin
            ready_q <= 1'b1;
            we_q    <= 1'b0;
            if (accept) begin
                case (state)
                    S_IDLE: begin
                        case (op)
                            OP_CTRL: begin
                                if (arg) halt_q <= 1'b1;
                            end
                            OP_SET_ADDR: begin
                                sel    <= arg;
                                err_q  <= 1'b0;
                                halt_q <= 1'b1;
                            end
                            OP_BURST: begin
                                cnt    <= bus.in_data[5:0];
                                csum   <= '0;
                                halt_q <= 1'b1;
                            end
                            default: halt_q <= 1'b0;
                        endcase
                    end
                    S_ADDR: begin
                        ptr <= bus.in_data[ADDR_W-1:0];
                    end
                    S_DATA: begin
                        // Out-of-range words are still consumed and still advance the pointer
                        if (in_range) begin
                            we_q    <= 1'b1;
                            addr_q  <= ptr;
                            wdata_q <= bus.in_data;
                        end else begin
                            err_q <= 1'b1;
                        end
                        ptr  <= ptr + ADDR_W'(1);
                        csum <= csum ^ bus.in_data;
                        if (cnt != 6'd0) cnt <= cnt - 6'd1;
                    end
`ifdef LOADER_CHECKSUM_EN
                    S_CHK: begin
                        if (bus.in_data != csum) err_q <= 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_stream_loader.sv
// tb/tb_cpu_stream_loader.sv - self-checking bench for cpu_stream_loader with directed and randomized frames
module tb_cpu_stream_loader;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 5;
    localparam int IMEM_DEPTH = 32;
    localparam int DMEM_DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    logic cpu_halt;
    logic busy;
    logic err;

    cpu_stream_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    cpu_stream_loader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .cpu_halt(cpu_halt), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: frame parsing by word counting
    int       m_ptr;
    bit       m_sel;
    bit       m_err;
    bit       m_halt;
    int       m_left;
    bit       m_want_addr;
    bit       m_want_chk;
    bit [7:0] m_csum;
    bit       m_we;
    int       m_addr;
    bit [7:0] m_data;
    bit       m_busy;

    task automatic model_reset();
        m_ptr = 0; m_sel = 0; m_err = 0; m_halt = 1; m_left = 0;
        m_want_addr = 0; m_want_chk = 0; m_csum = 0; m_we = 0; m_busy = 0;
    endtask

    task automatic model_step(input bit [7:0] w);
        int depth;
        m_we = 0;
        if (m_want_addr) begin
            m_ptr = int'(w) % (1 << ADDR_W);
            m_want_addr = 0;
        end else if (m_left > 0) begin
            depth = m_sel ? IMEM_DEPTH : DMEM_DEPTH;
            if (m_ptr < depth) begin
                m_we = 1; m_addr = m_ptr; m_data = w;
            end else begin
                m_err = 1;
            end
            m_ptr  = (m_ptr + 1) % (1 << ADDR_W);
            m_csum = m_csum ^ w;
            m_left = m_left - 1;
`ifdef LOADER_CHECKSUM_EN
            if (m_left == 0) m_want_chk = 1;
`endif
        end else if (m_want_chk) begin
            if (w != m_csum) m_err = 1;
            m_want_chk = 0;
        end else begin
            case (w[7:6])
                2'b00: if (w[5]) m_halt = 1;
                2'b01: begin m_sel = w[5]; m_want_addr = 1; m_err = 0; m_halt = 1; end
                2'b10: begin m_left = int'(w[5:0]) + 1; m_csum = 0; m_halt = 1; end
                default: m_halt = 0;
            endcase
        end
        m_busy = m_want_addr || (m_left > 0) || m_want_chk;
    endtask

    // Presents one word at a negedge and returns at the negedge after it is accepted
    task automatic put_word(input logic [7:0] w);
        bit done;
        done = 0;
        for (int t = 0; t < 16 && !done; t++) begin
            bus.in_data  = w;
            bus.in_valid = 1'b1;
            done = (bus.in_ready === 1'b1);
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL accept_timeout word=%h in_ready=%b want 1", w, bus.in_ready);
        end else begin
            model_step(w);
        end
    endtask

    task automatic idle_cycle();
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
        n_tests++; if (cpu_halt !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_halt got %b want 1", cpu_halt); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", err); end
        n_tests++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got %b want 0", bus.mem_we); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        n_tests++; if (bus.mem_addr !== 5'd0) begin n_fail++; $display("FAIL rst_mem_addr got %h want 0", bus.mem_addr); end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready got %b want 1", bus.in_ready); end
        n_tests++; if (cpu_halt !== 1'b1) begin n_fail++; $display("FAIL post_rst_cpu_halt got %b want 1", cpu_halt); end
    endtask

    task automatic test_imem_burst();
        logic [7:0] d [3];
        d = '{8'hAA, 8'hBB, 8'hCC};
        put_word(8'h60);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL imem_busy_addr got %b want 1", busy); end
        put_word(8'h04);
        put_word(8'h82);
        n_tests++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL imem_cmd_we got %b want 0", bus.mem_we); end
        for (int i = 0; i < 3; i++) begin
            put_word(d[i]);
            n_tests++;
            if (bus.mem_we !== 1'b1 || bus.mem_sel !== 1'b1 || bus.mem_addr !== 5'(4 + i) || bus.mem_wdata !== d[i]) begin
                n_fail++;
                $display("FAIL imem_write%0d got we=%b sel=%b addr=%0d data=%h want we=1 sel=1 addr=%0d data=%h",
                         i, bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata, 4 + i, d[i]);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        put_word(8'hDD);
`endif
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL imem_busy_end got %b want 0", busy); end
        idle_cycle();
        n_tests++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL imem_we_after got %b want 0", bus.mem_we); end
    endtask

    task automatic test_wrap();
        put_word(8'h60);
        put_word(8'h1F);
        put_word(8'h81);
        put_word(8'h11);
        n_tests++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 5'd31 || bus.mem_wdata !== 8'h11) begin
            n_fail++; $display("FAIL wrap_first got we=%b addr=%0d data=%h want we=1 addr=31 data=11", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        put_word(8'h22);
        n_tests++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 5'd0 || bus.mem_wdata !== 8'h22) begin
            n_fail++; $display("FAIL wrap_second got we=%b addr=%0d data=%h want we=1 addr=0 data=22", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
`ifdef LOADER_CHECKSUM_EN
        put_word(8'h33);
`endif
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL wrap_err got %b want 0", err); end
    endtask

    task automatic test_out_of_range();
        put_word(8'h40);
        put_word(8'h0F);
        put_word(8'h81);
        put_word(8'h01);
        n_tests++; if (bus.mem_we !== 1'b1 || bus.mem_sel !== 1'b0 || bus.mem_addr !== 5'd15 || bus.mem_wdata !== 8'h01) begin
            n_fail++; $display("FAIL oor_in_range got we=%b sel=%b addr=%0d data=%h want we=1 sel=0 addr=15 data=01",
                               bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL oor_err_early got %b want 0", err); end
        put_word(8'h02);
        n_tests++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL oor_suppress got we=%b want 0", bus.mem_we); end
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_err_set got %b want 1", err); end
`ifdef LOADER_CHECKSUM_EN
        put_word(8'h03);
`endif
        idle_cycle();
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_err_sticky got %b want 1", err); end
        put_word(8'h40);
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL oor_err_clear got %b want 0", err); end
        put_word(8'h00);
    endtask

    task automatic test_run_halt();
        put_word(8'hC0);
        n_tests++; if (cpu_halt !== 1'b0) begin n_fail++; $display("FAIL run_release got %b want 0", cpu_halt); end
        put_word(8'hC0);
        n_tests++; if (cpu_halt !== 1'b0) begin n_fail++; $display("FAIL run_nop got %b want 0", cpu_halt); end
        put_word(8'h00);
        n_tests++; if (cpu_halt !== 1'b0) begin n_fail++; $display("FAIL ctrl_nop got %b want 0", cpu_halt); end
        put_word(8'h20);
        n_tests++; if (cpu_halt !== 1'b1) begin n_fail++; $display("FAIL ctrl_halt got %b want 1", cpu_halt); end
        put_word(8'hC0);
        put_word(8'h80);
        n_tests++; if (cpu_halt !== 1'b1 || bus.mem_we !== 1'b0) begin
            n_fail++; $display("FAIL burst_force_halt got halt=%b we=%b want halt=1 we=0", cpu_halt, bus.mem_we); end
        put_word(8'h55);
        n_tests++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 5'd0 || bus.mem_wdata !== 8'h55) begin
            n_fail++; $display("FAIL burst_after_run got we=%b addr=%0d data=%h want we=1 addr=0 data=55", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
`ifdef LOADER_CHECKSUM_EN
        put_word(8'h55);
`endif
        put_word(8'hC0);
        put_word(8'h83);
        put_word(8'h01);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        n_tests++; if (busy !== 1'b0 || cpu_halt !== 1'b1 || bus.mem_we !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_burst got busy=%b halt=%b we=%b want busy=0 halt=1 we=0", busy, cpu_halt, bus.mem_we); end
        reset = 1'b0;
        idle_cycle();
        put_word(8'h12);
        n_tests++; if (busy !== 1'b0 || bus.mem_we !== 1'b0) begin
            n_fail++; $display("FAIL reset_fresh_frame got busy=%b we=%b want busy=0 we=0", busy, bus.mem_we); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        put_word(8'h40);
        put_word(8'h00);
        put_word(8'h81);
        put_word(8'h0F);
        put_word(8'hF0);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL chk_wait got busy=%b want 1", busy); end
        put_word(8'hFF);
        n_tests++; if (err !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL chk_good got err=%b busy=%b want err=0 busy=0", err, busy); end
        put_word(8'h40);
        put_word(8'h00);
        put_word(8'h81);
        put_word(8'h0F);
        n_tests++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 5'd0) begin
            n_fail++; $display("FAIL chk_bad_w0 got we=%b addr=%0d want we=1 addr=0", bus.mem_we, bus.mem_addr); end
        put_word(8'hF0);
        n_tests++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 5'd1) begin
            n_fail++; $display("FAIL chk_bad_w1 got we=%b addr=%0d want we=1 addr=1", bus.mem_we, bus.mem_addr); end
        put_word(8'h00);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL chk_bad_err got %b want 1", err); end
    endtask
`endif

    task automatic test_random();
        logic [7:0] q [$];
        int         kind;
        int         len;
        logic [7:0] d;
        logic [7:0] cs;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        idle_cycle();
        for (int f = 0; f < 60; f++) begin
            q.delete();
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    q.push_back({2'b01, 1'($urandom), 5'($urandom)});
                    q.push_back(8'($urandom));
                end
                1: begin
                    len = $urandom_range(1, 8);
                    q.push_back(8'h80 | 8'(len - 1));
                    cs = 8'h00;
                    for (int i = 0; i < len; i++) begin
                        d = 8'($urandom);
                        cs = cs ^ d;
                        q.push_back(d);
                    end
`ifdef LOADER_CHECKSUM_EN
                    if ($urandom_range(0, 3) == 0) q.push_back(cs ^ 8'($urandom_range(1, 255)));
                    else                           q.push_back(cs);
`endif
                end
                2: q.push_back({2'b11, 6'($urandom)});
                default: q.push_back({2'b00, 6'($urandom)});
            endcase
            for (int i = 0; i < q.size(); i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    idle_cycle();
                    n_tests++; if (bus.mem_we !== 1'b0 || busy !== m_busy) begin
                        n_fail++; $display("FAIL rnd_gap f=%0d got we=%b busy=%b want we=0 busy=%b", f, bus.mem_we, busy, m_busy); end
                end
                put_word(q[i]);
                n_tests++; if (bus.mem_we !== m_we) begin
                    n_fail++; $display("FAIL rnd_we f=%0d w=%h got %b want %b", f, q[i], bus.mem_we, m_we); end
                if (m_we) begin
                    n_tests++; if (bus.mem_addr !== 5'(m_addr) || bus.mem_wdata !== m_data || bus.mem_sel !== m_sel) begin
                        n_fail++; $display("FAIL rnd_write f=%0d got sel=%b addr=%0d data=%h want sel=%b addr=%0d data=%h",
                                           f, bus.mem_sel, bus.mem_addr, bus.mem_wdata, m_sel, m_addr, m_data); end
                end
                n_tests++; if (err !== m_err || cpu_halt !== m_halt || busy !== m_busy) begin
                    n_fail++; $display("FAIL rnd_status f=%0d got err=%b halt=%b busy=%b want err=%b halt=%b busy=%b",
                                       f, err, cpu_halt, busy, m_err, m_halt, m_busy); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_imem_burst();
        test_wrap();
        test_out_of_range();
        test_run_halt();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
